// File: rtl/booth_operand_sequencer.sv
// Feeds queued operand pairs to booth_multiplier one at a time and returns products on a ready/valid port.
// Push-to-start is 2 cycles; s_ready drops only when the FIFO is full, and m_ready stalls hold the product.
module booth_operand_sequencer_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_vld,
  output logic          wr_rdy,
  input  logic [DW-1:0] wr_dat,
  output logic          rd_vld,
  input  logic          rd_rdy,
  output logic [DW-1:0] rd_dat
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          full, empty, push, pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  always_comb begin
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty    = (wr_ptr_q == rd_ptr_q);
    wr_rdy   = !full;
    rd_vld   = !empty;
    push     = wr_vld && !full;
    pop      = rd_rdy && !empty;
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    rd_dat   = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
  end
endmodule

module booth_operand_sequencer #(
  parameter int WIDTH_INPUT  = 16,
  parameter int WIDTH_OUTPUT = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [WIDTH_INPUT-1:0]  s_a,
  input  logic [WIDTH_INPUT-1:0]  s_b,
  output logic [WIDTH_INPUT-1:0]  mul_in_a,
  output logic [WIDTH_INPUT-1:0]  mul_in_b,
  output logic                    mul_valid_in,
  input  logic                    mul_valid_out,
  input  logic [WIDTH_OUTPUT-1:0] mul_product,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [WIDTH_OUTPUT-1:0] m_product,
  output logic [CNT_WIDTH-1:0]    res_count,
  output logic                    busy
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, OUTPUT} state_t;

  state_t                  state_q, state_d;
  logic [WIDTH_INPUT-1:0]  mul_in_a_q, mul_in_a_d;
  logic [WIDTH_INPUT-1:0]  mul_in_b_q, mul_in_b_d;
  logic [WIDTH_OUTPUT-1:0] m_product_q, m_product_d;
  logic [CNT_WIDTH-1:0]    res_count_q, res_count_d;

  logic                     fifo_rd_vld, fifo_rd_rdy;
  logic [2*WIDTH_INPUT-1:0] fifo_rd_dat;

  booth_operand_sequencer_fifo #(
    .DW    (2*WIDTH_INPUT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (s_valid),
    .wr_rdy (s_ready),
    .wr_dat ({s_a, s_b}),
    .rd_vld (fifo_rd_vld),
    .rd_rdy (fifo_rd_rdy),
    .rd_dat (fifo_rd_dat)
  );

  always_comb begin
    state_d     = state_q;
    mul_in_a_d  = mul_in_a_q;
    mul_in_b_d  = mul_in_b_q;
    m_product_d = m_product_q;
    res_count_d = res_count_q;
    fifo_rd_rdy = 1'b0;
    case (state_q)
      IDLE: begin
        fifo_rd_rdy = 1'b1;
        if (fifo_rd_vld) begin
          mul_in_a_d = fifo_rd_dat[2*WIDTH_INPUT-1:WIDTH_INPUT];
          mul_in_b_d = fifo_rd_dat[WIDTH_INPUT-1:0];
          state_d    = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_HI;
      WAIT_HI: begin
        if (mul_valid_out) begin
          m_product_d = mul_product;
          state_d     = WAIT_LO;
        end
      end
      // Never restart until the multiplier has dropped valid_out.
      WAIT_LO: if (!mul_valid_out) state_d = OUTPUT;
      OUTPUT: begin
        if (m_ready) begin
          res_count_d = res_count_q + CNT_WIDTH'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mul_in_a_q  <= '0;
      mul_in_b_q  <= '0;
      m_product_q <= '0;
      res_count_q <= '0;
    end else begin
      state_q     <= state_d;
      mul_in_a_q  <= mul_in_a_d;
      mul_in_b_q  <= mul_in_b_d;
      m_product_q <= m_product_d;
      res_count_q <= res_count_d;
    end
  end

  assign mul_in_a     = mul_in_a_q;
  assign mul_in_b     = mul_in_b_q;
  assign mul_valid_in = (state_q == ISSUE);
  assign m_valid      = (state_q == OUTPUT);
  assign m_product    = m_product_q;
  assign res_count    = res_count_q;
  assign busy         = (state_q != IDLE) || fifo_rd_vld;
endmodule

// File: tb/tb_booth_operand_sequencer.sv
// Directed bench for booth_operand_sequencer with a behavioural signed multiplier
// of programmable latency and valid_out hold length.
module tb_booth_operand_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_a = '0, s_b = '0;
  logic [15:0] mul_in_a, mul_in_b;
  logic        mul_valid_in;
  logic        mul_valid_out = 1'b0;
  logic [31:0] mul_product = 32'hDEADBEEF;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_product;
  logic [7:0]  res_count;
  logic        busy;

  int n_chk = 0, n_fail = 0;
  int lat = 3, hold_len = 1;
  int mdl_cnt = 0, hold_left = 0, starts = 0, viol = 0;
  logic [31:0] mdl_prod = '0;

  booth_operand_sequencer dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .mul_in_a(mul_in_a), .mul_in_b(mul_in_b), .mul_valid_in(mul_valid_in),
    .mul_valid_out(mul_valid_out), .mul_product(mul_product),
    .m_valid(m_valid), .m_ready(m_ready), .m_product(m_product),
    .res_count(res_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Multiplier model: product appears 'lat' cycles after the start pulse, valid_out
  // stays high 'hold_len' cycles and the bus is corrupted after the first of them.
  always @(negedge clk) begin
    if (!reset) begin
      mdl_cnt = 0; hold_left = 0;
      mul_valid_out = 1'b0; mul_product = 32'hDEADBEEF;
    end else begin
      if (mul_valid_in && mul_valid_out) viol = viol + 1;
      if (mul_valid_out) begin
        hold_left = hold_left - 1;
        if (hold_left == 0) begin
          mul_valid_out = 1'b0; mul_product = 32'hDEADBEEF;
        end else mul_product = 32'h12345678;
      end
      if (mdl_cnt > 0) begin
        mdl_cnt = mdl_cnt - 1;
        if (mdl_cnt == 0) begin
          mul_valid_out = 1'b1; mul_product = mdl_prod; hold_left = hold_len;
        end
      end
      if (mul_valid_in) begin
        mdl_prod = 32'($signed({{16{mul_in_a[15]}}, mul_in_a}) * $signed({{16{mul_in_b[15]}}, mul_in_b}));
        mdl_cnt = lat;
        starts = starts + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    int k = 0;
    s_valid = 1'b1; s_a = a; s_b = b;
    while (!s_ready && k < 200) begin @(posedge clk); #1; k++; end
    if (!s_ready) chk("push_timeout", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic get_result(input string tag, input logic [31:0] exp);
    int k = 0;
    m_ready = 1'b1;
    while (!m_valid && k < 100) begin @(posedge clk); #1; k++; end
    chk({tag, "_vld"}, 32'(m_valid), 32'd1);
    chk(tag, m_product, exp);
    @(posedge clk); #1;
    m_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st0, v0, k, mv_cnt;
    logic [31:0] p0;

    // Reset state and single transaction
    do_reset();
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_mul_in_a", 32'(mul_in_a), 32'd0);
    chk("rst_mul_in_b", 32'(mul_in_b), 32'd0);
    chk("rst_mul_valid_in", 32'(mul_valid_in), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_product", m_product, 32'd0);
    chk("rst_res_count", 32'(res_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    st0 = starts;
    push(16'h0003, 16'h0005);
    chk("lat_no_bypass", 32'(mul_valid_in), 32'd0);
    chk("lat_busy_queued", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("lat_valid_in", 32'(mul_valid_in), 32'd1);
    chk("lat_mul_in_a", 32'(mul_in_a), 32'h3);
    chk("lat_mul_in_b", 32'(mul_in_b), 32'h5);
    @(posedge clk); #1;
    chk("pulse_one_cycle", 32'(mul_valid_in), 32'd0);
    get_result("single_prod", 32'h0000000F);
    chk("single_count", 32'(res_count), 32'd1);
    chk("single_busy", 32'(busy), 32'd0);
    chk("single_starts", 32'(starts - st0), 32'd1);

    // Back-to-back pushes
    do_reset();
    chk("b2b_rdy0", 32'(s_ready), 32'd1); push(16'd2, 16'd3);
    chk("b2b_rdy1", 32'(s_ready), 32'd1); push(16'd7, 16'd9);
    chk("b2b_rdy2", 32'(s_ready), 32'd1); push(16'hFFFE, 16'd7);
    chk("b2b_rdy3", 32'(s_ready), 32'd1); push(16'd100, 16'd200);
    get_result("b2b_p0", 32'd6);
    get_result("b2b_p1", 32'd63);
    get_result("b2b_p2", 32'hFFFFFFF2);
    get_result("b2b_p3", 32'd20000);
    chk("b2b_count", 32'(res_count), 32'd4);

    // Downstream stall: one in flight plus four buffered
    do_reset();
    push(16'd10, 16'd10);
    push(16'hFFFF, 16'hFFFF);
    push(16'h8000, 16'd2);
    push(16'h7FFF, 16'h7FFF);
    push(16'd0, 16'd1234);
    chk("stall_full", 32'(s_ready), 32'd0);
    k = 0;
    while (!m_valid && k < 100) begin @(posedge clk); #1; k++; end
    chk("stall_vld", 32'(m_valid), 32'd1);
    p0 = m_product;
    chk("stall_first", p0, 32'h00000064);
    repeat (5) @(posedge clk);
    #1;
    chk("stall_hold_prod", m_product, 32'h00000064);
    chk("stall_hold_vld", 32'(m_valid), 32'd1);
    chk("stall_still_full", 32'(s_ready), 32'd0);
    get_result("drain_p0", 32'h00000064);
    get_result("drain_p1", 32'h00000001);
    get_result("drain_p2", 32'hFFFF0000);
    get_result("drain_p3", 32'h3FFF0001);
    get_result("drain_p4", 32'h00000000);
    chk("drain_count", 32'(res_count), 32'd5);
    chk("drain_busy", 32'(busy), 32'd0);

    // valid_out held for three cycles
    do_reset();
    hold_len = 3;
    st0 = starts; v0 = viol;
    push(16'd6, 16'd7);
    push(16'd3, 16'd3);
    get_result("hold_p0", 32'd42);
    get_result("hold_p1", 32'd9);
    chk("hold_starts", 32'(starts - st0), 32'd2);
    chk("hold_no_overlap", 32'(viol - v0), 32'd0);
    chk("hold_count", 32'(res_count), 32'd2);
    hold_len = 1;

    // Reset while waiting on the multiplier with two pairs queued
    do_reset();
    lat = 10;
    push(16'd1, 16'd2);
    push(16'd3, 16'd4);
    push(16'd5, 16'd6);
    chk("mid_pre_busy", 32'(busy), 32'd1);
    chk("mid_pre_a", 32'(mul_in_a), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_s_ready", 32'(s_ready), 32'd1);
    chk("mid_mul_in_a", 32'(mul_in_a), 32'd0);
    chk("mid_mul_in_b", 32'(mul_in_b), 32'd0);
    chk("mid_valid_in", 32'(mul_valid_in), 32'd0);
    chk("mid_m_valid", 32'(m_valid), 32'd0);
    chk("mid_m_product", m_product, 32'd0);
    chk("mid_res_count", 32'(res_count), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    m_ready = 1'b1;
    st0 = starts; mv_cnt = 0;
    repeat (30) begin @(posedge clk); #1; if (m_valid) mv_cnt++; end
    m_ready = 1'b0;
    chk("post_no_m_valid", 32'(mv_cnt), 32'd0);
    chk("post_no_start", 32'(starts - st0), 32'd0);
    chk("post_s_ready", 32'(s_ready), 32'd1);
    chk("post_busy", 32'(busy), 32'd0);

    // Result counter wrap
    do_reset();
    lat = 1;
    for (int i = 0; i < 255; i++) begin
      push(16'(i), 16'd2);
      get_result("wrap_prod", 32'(2 * i));
    end
    chk("wrap_ff", 32'(res_count), 32'h000000FF);
    push(16'd255, 16'd2);
    get_result("wrap_last", 32'd510);
    chk("wrap_00", 32'(res_count), 32'h00000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/booth_operand_sequencer.md
Name: booth_operand_sequencer

Overview:
- Upstream feeder and result collector for booth_multiplier.
- Buffers operand pairs from a ready/valid producer in a small FIFO.
- Issues one pair at a time to the multiplier using its valid_in/valid_out protocol, captures the product, and presents it on a ready/valid result port.
- Hides the multiplier's multi-cycle, non-pipelined latency from the rest of the datapath.

Parameters:
- WIDTH_INPUT, 16, operand width. Must match booth_multiplier.
- WIDTH_OUTPUT, 32, product width. Equals 2*WIDTH_INPUT.
- FIFO_DEPTH, 4, operand FIFO entries. Power of two, >=2.
- CNT_WIDTH, 8, width of the completed-result counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- s_valid  in  1  upstream operand pair valid.
- s_ready  out  1  FIFO can accept a pair.
- s_a  in  WIDTH_INPUT  multiplicand.
- s_b  in  WIDTH_INPUT  multiplier.
- mul_in_a  out  WIDTH_INPUT  to booth_multiplier in_a.
- mul_in_b  out  WIDTH_INPUT  to booth_multiplier in_b.
- mul_valid_in  out  1  one-cycle start pulse to booth_multiplier.
- mul_valid_out  in  1  booth_multiplier valid_out.
- mul_product  in  WIDTH_OUTPUT  booth_multiplier product.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- m_product  out  WIDTH_OUTPUT  captured product.
- res_count  out  CNT_WIDTH  number of results delivered, wraps.
- busy  out  1  high whenever FSM is not IDLE or FIFO is non-empty.

Behaviour:
- Reset: reset low clears everything immediately, regardless of clock. FIFO is emptied and pointers zeroed. FSM goes to IDLE. Output values during reset:
  - s_ready=1 (once reset deasserts, since FIFO is empty)
  - mul_in_a=0, mul_in_b=0, mul_valid_in=0
  - m_valid=0, m_product=0
  - res_count=0, busy=0
- Reset mid-operation: any in-flight pair and any FIFO contents are dropped. No result is emitted.
- FIFO:
  - Push when s_valid && s_ready. s_ready = !full.
  - Pop only in IDLE when non-empty.
  - No bypass: a pushed pair becomes poppable the cycle after the push.
  - When full, s_ready=0 even if a pop occurs in the same cycle.
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full/empty are decided by MSB comparison.
- FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO, OUTPUT.
  - IDLE: if FIFO non-empty, pop the head into registers mul_in_a/mul_in_b and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: mul_valid_in=1 for exactly this one cycle, then go to WAIT_HI.
  - WAIT_HI: on the first cycle mul_valid_out=1, register mul_product into m_product and go to WAIT_LO.
  - WAIT_LO: wait for mul_valid_out=0, then go to OUTPUT. This guarantees the multiplier has fully completed before the next start.
  - OUTPUT: m_valid=1. On m_valid && m_ready, increment res_count (mod 2^CNT_WIDTH) and go to IDLE. m_product is held stable while m_valid=1 && !m_ready.
- mul_in_a and mul_in_b are held constant from the IDLE pop until the FSM next returns to IDLE.
- mul_valid_out is ignored in IDLE, ISSUE and OUTPUT.
- Arithmetic: none. m_product is a bit-exact copy of mul_product. Signedness is defined by booth_multiplier (two's complement).
- Latency from FIFO push to mul_valid_in: push at edge t; pop at edge t+1; mul_valid_in is high during the cycle after edge t+1.
- Throughput: one pair per multiplier latency + 3 cycles (minimum), plus downstream stall.
- Ordering: results are delivered strictly in push order.

Test Plan:
- After reset release, push s_a=16'h0003, s_b=16'h0005 -> exactly one mul_valid_in pulse; m_valid rises with m_product=32'h0000000F; after the handshake res_count=1 and busy=0.
- Back-to-back pushes (4 pairs) on consecutive cycles of (2,3), (7,9), (16'hFFFE,7), (100,200) -> s_ready stays 1. Results arrive in order: 6, 63, 32'hFFFFFFF2, 20000. res_count=4.
- Push 5 pairs while m_ready=0 -> s_ready drops after the FIFO holds 4 pairs (1 in flight, 4 buffered). m_product is stable while stalled. Releasing m_ready drains all pairs in order.
- Hold mul_valid_out high for 3 cycles on completion -> only one result is captured. No new mul_valid_in until mul_valid_out returns low.
- Assert reset low in WAIT_HI with 2 pairs queued -> all outputs reach reset values immediately. After release, no m_valid appears and s_ready=1.
- 256 completed results -> res_count wraps from 8'hFF to 8'h00.
